cache_refill_unit: RTL and testbench
====================================

# cache_refill_unit

Memory-side refill engine sitting directly downstream of the blocking cache datapath/control. On a miss the cache control hands it a line address. The unit issues the 16 single-word read requests for that 64-byte line to main memory, with up to `MAX_OUTSTANDING` in flight. It streams each returned word, tagged with its word index, back to the data-array write path and pulses `refill_done` when the line is complete.

## Interface
- `LINE_WORDS`, 16, words per line; fixed by the 64 B line and 4 B word.
- `MAX_OUTSTANDING`, 4, maximum issued-but-unanswered memory requests; legal range 1..16.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `refill_req_val` in 1: cache control requests a line refill.
- `refill_req_rdy` out 1: unit can accept a refill.
- `refill_req_addr` in 32: miss address; bits [5:0] ignored.
- `memreq_val` out 1: memory request valid.
- `memreq_rdy` in 1: memory can accept a request.
- `memreq_msg` out `mem_req_4B_t`: read request to memory.
- `memresp_val` in 1: memory response valid.
- `memresp_rdy` out 1: unit can accept a response.
- `memresp_msg` in `mem_resp_4B_t`: read response from memory.
- `word_val` out 1: a refill word is presented this cycle.
- `word_idx` out 4: word offset within the line, 0..15.
- `word_data` out 32: refill word data.
- `refill_done` out 1: one-cycle pulse after the last word.

## Operation
- FSM states:
  - `IDLE`: `refill_req_rdy`=1. On `refill_req_val`, capture `base = refill_req_addr[31:6]`, clear counters, and go to `BUSY`.
  - `BUSY`: issue requests and accept responses concurrently. When `issue_cnt`==16 and `resp_cnt`==16, go to `DONE`.
  - `DONE`: `refill_done`=1 for exactly one cycle, then go to `IDLE`.
- Counters `issue_cnt` and `resp_cnt` are 5 bits each, range 0..16. `outstanding = issue_cnt - resp_cnt`.
- `memreq_val` = BUSY && `issue_cnt` < 16 && `outstanding` < `MAX_OUTSTANDING`. `issue_cnt` increments on `memreq_val && memreq_rdy`.
- `memreq_msg` fields:
  - type_ = read
  - opaque = {4'b0, `issue_cnt`[3:0]}
  - addr = {base, `issue_cnt`[3:0], 2'b00}
  - len = 0
  - data = 0
- `memresp_rdy` = BUSY && `outstanding` > 0. `resp_cnt` increments on `memresp_val && memresp_rdy`.
- Responses may return out of order. `word_idx` = `memresp_msg.opaque`[3:0], never a count.
- `word_val` = `memresp_val && memresp_rdy`. `word_data` = `memresp_msg.data`. Both paths are combinational, zero latency, no buffering.
- A response with type_ != read, or with opaque[7:4] != 0, is a protocol error and fires a simulation assertion.
- Simultaneous issue and response in one cycle: both counters update, and `outstanding` is unchanged.
- `refill_req_val` while not IDLE is ignored; `refill_req_rdy`=0 then.

## Timing
- Reset values: state IDLE, counters 0, base 0. Outputs: `refill_req_rdy`=1, `memreq_val`=0, `memresp_rdy`=0, `word_val`=0, `refill_done`=0.
- Reset mid-refill returns to IDLE on the next edge and drops all in-flight state. The memory model must be reset with the unit.
- Refill accepted at edge 0 → first `memreq_val` in cycle 1.
- With `memreq_rdy`=1 and memory latency L ≤ `MAX_OUTSTANDING`-1, requests issue back-to-back in cycles 1..16.
- The last word arrives in cycle 16+L, `refill_done` is high in cycle 17+L, and `refill_req_rdy`=1 in cycle 18+L.
- When `outstanding` == `MAX_OUTSTANDING`, issue stalls until a response is accepted. The freed slot can issue in the cycle after that acceptance, not the same cycle.
- `memreq_msg` is held stable while `memreq_val && !memreq_rdy`.

## Structure
- Shared package `lab3_cache/CacheConsts.v`: line-words, word-offset bits (4), line-offset bits (6), and tag/index widths shared with the cache datapath. Message structs come from `vc/mem-msgs.v`.
- One natural sub-module, `cache_refill_credit_cnt`: holds the paired issue/response counters and produces `outstanding`, `all_issued` and `all_returned`. The FSM and message formatting stay in the top.

## Test plan
- Refill `0x0000_1234`, memory L=1, `memreq_rdy`=1 → 16 requests to `0x1200`..`0x123C` in cycles 1..16; `word_idx` 0..15 in order; `refill_done` in cycle 18.
- `MAX_OUTSTANDING`=4, memory L=10 → never more than 4 unanswered requests; the stall pattern is visible on `memreq_val`; all 16 words are delivered.
- Memory returns responses in reverse order per batch → `word_idx` matches opaque each time; every index 0..15 is seen exactly once; `refill_done` fires once.
- Random `memreq_rdy` and `memresp_val` backpressure → `memreq_msg` is stable while stalled; no request is dropped or duplicated.
- Assert `reset` after 7 responses → next cycle IDLE, `refill_req_rdy`=1, no `word_val`; a new refill of `0xABCD_0040` completes correctly.
- Hold `refill_req_val` high through a whole refill → exactly one refill per IDLE acceptance; the second starts in the cycle after `refill_done`.

Source files
------------

// File: rtl/cache_refill_unit_pkg.sv
// cache_refill_unit_pkg: line geometry, FSM states and memory message formats for the refill engine.
package cache_refill_unit_pkg;
    localparam int LINE_WORDS    = 16;
    localparam int WORD_OFF_BITS = 4;
    localparam int LINE_OFF_BITS = 6;
    localparam int BASE_BITS     = 32 - LINE_OFF_BITS;
    localparam int CNT_BITS      = 5;
    localparam logic [2:0] MEM_READ = 3'd0;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;
    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;
endpackage

// File: rtl/cache_refill_credit_cnt.sv
// cache_refill_credit_cnt: paired issue/response counters tracking in-flight refill requests.
module cache_refill_credit_cnt
    import cache_refill_unit_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     issue,
    input  logic                     resp,
    output logic [WORD_OFF_BITS-1:0] issue_idx,
    output logic [CNT_BITS-1:0]      outstanding,
    output logic                     all_issued,
    output logic                     all_returned
);
    localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(LINE_WORDS);
    logic [CNT_BITS-1:0] issue_cnt, resp_cnt;
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            issue_cnt <= '0;
            resp_cnt  <= '0;
        end else begin
            issue_cnt <= issue_cnt + CNT_BITS'(issue);
            resp_cnt  <= resp_cnt + CNT_BITS'(resp);
        end
    end
    // all_returned counts the response accepted this cycle so DONE follows the last word directly
    always_comb begin
        issue_idx    = issue_cnt[WORD_OFF_BITS-1:0];
        outstanding  = issue_cnt - resp_cnt;
        all_issued   = issue_cnt == FULL;
        all_returned = resp_cnt + CNT_BITS'(resp) == FULL;
    end
endmodule

// File: rtl/cache_refill_unit.sv
// cache_refill_unit: fetches a 16-word line from memory with bounded outstanding reads, streaming words back.
module cache_refill_unit
    import cache_refill_unit_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     refill_req_val,
    output logic                     refill_req_rdy,
    input  logic [31:0]              refill_req_addr,
    output logic                     memreq_val,
    input  logic                     memreq_rdy,
    output mem_req_4B_t              memreq_msg,
    input  logic                     memresp_val,
    output logic                     memresp_rdy,
    input  mem_resp_4B_t             memresp_msg,
    output logic                     word_val,
    output logic [WORD_OFF_BITS-1:0] word_idx,
    output logic [31:0]              word_data,
    output logic                     refill_done
);
    localparam logic [CNT_BITS-1:0] MAX_OUT = CNT_BITS'(MAX_OUTSTANDING);
    state_t                   state, state_next;
    logic [BASE_BITS-1:0]     base;
    logic [WORD_OFF_BITS-1:0] issue_idx;
    logic [CNT_BITS-1:0]      outstanding;
    logic                     all_issued, all_returned, accept, unused;

    cache_refill_credit_cnt credit (
        .clk          (clk),
        .reset        (reset),
        .clear        (accept),
        .issue        (memreq_val && memreq_rdy),
        .resp         (word_val),
        .issue_idx    (issue_idx),
        .outstanding  (outstanding),
        .all_issued   (all_issued),
        .all_returned (all_returned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            base  <= '0;
        end else begin
            state <= state_next;
            if (accept) base <= refill_req_addr[31:LINE_OFF_BITS];
        end
    end

    always_comb
        state_next = (state == IDLE && refill_req_val)              ? BUSY :
                     (state == BUSY && all_issued && all_returned)  ? DONE :
                     (state == DONE)                                ? IDLE : state;

    always_comb begin
        refill_req_rdy = state == IDLE;
        accept         = refill_req_rdy && refill_req_val;
        memreq_val     = state == BUSY && !all_issued && outstanding < MAX_OUT;
        memreq_msg     = '{MEM_READ, {4'b0, issue_idx}, {base, issue_idx, 2'b00}, 2'd0, 32'd0};
        memresp_rdy    = state == BUSY && outstanding != '0;
        word_val       = memresp_val && memresp_rdy;
        word_idx       = memresp_msg.opaque[WORD_OFF_BITS-1:0];
        word_data      = memresp_msg.data;
        refill_done    = state == DONE;
        unused         = ^{refill_req_addr[LINE_OFF_BITS-1:0], memresp_msg.test, memresp_msg.len,
                           memresp_msg.type_, memresp_msg.opaque[7:4]};
    end

    always_ff @(posedge clk)
        if (!reset && word_val)
            assert (memresp_msg.type_ == MEM_READ && memresp_msg.opaque[7:4] == 4'd0);
endmodule

// File: tb/tb_cache_refill_unit.sv
// tb_cache_refill_unit: randomized refills against a queue-based memory and refill scoreboard.
module tb_cache_refill_unit;
    import cache_refill_unit_pkg::*;
    localparam int MAXO = 4;

    logic         clk, reset, refill_req_val, refill_req_rdy, memreq_val, memreq_rdy;
    logic         memresp_val, memresp_rdy, word_val, refill_done;
    logic [31:0]  refill_req_addr, word_data;
    logic [3:0]   word_idx;
    mem_req_4B_t  memreq_msg;
    mem_resp_4B_t memresp_msg;

    cache_refill_unit #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset(reset), .refill_req_val(refill_req_val), .refill_req_rdy(refill_req_rdy),
        .refill_req_addr(refill_req_addr), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memreq_msg(memreq_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
        .memresp_msg(memresp_msg), .word_val(word_val), .word_idx(word_idx), .word_data(word_data),
        .refill_done(refill_done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] addr;
        int          rdy;
    } pend_t;

    pend_t       pend[$];
    int          word_order[$];
    int          seen[16];
    int          checks = 0, passes = 0, cyc = 0;
    int          phase = 0, issued = 0, responded = 0, lat = 1, mode = 0, drain_n = 0;
    int          acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_abs = 0, done_rel = 0;
    int          first_iss = 0, last_iss = 0, stall_cycles = 0, max_pend = 0;
    bit          rnd_rdy = 0, stalled = 0;
    logic [25:0] base = '0;
    mem_req_4B_t held;

    function automatic logic [31:0] mk_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5EED;
    endfunction

    // One clock cycle: drive memory side, check outputs against the scoreboard, advance the model.
    task automatic tick();
        int          pick, outs;
        bit          exp_rv, exp_sr;
        int          rdy_ix[$];
        mem_req_4B_t exp_req;
        pick = -1;
        if (!reset && phase == 1) begin
            if (mode == 0) begin
                if (pend.size() > 0 && pend[0].rdy <= cyc) pick = 0;
            end else if (mode == 1) begin
                if (drain_n == 0 && pend.size() > 0 && (pend.size() == MAXO || issued == 16)) drain_n = pend.size();
                if (drain_n > 0 && pend[drain_n-1].rdy <= cyc) pick = drain_n - 1;
            end else begin
                foreach (pend[i]) if (pend[i].rdy <= cyc) rdy_ix.push_back(i);
                if (rdy_ix.size() > 0 && $urandom_range(1, 0) == 1) pick = rdy_ix[$urandom_range(rdy_ix.size() - 1, 0)];
            end
        end
        memresp_val = pick >= 0;
        memresp_msg = '0;
        if (pick >= 0) begin
            memresp_msg.type_  = MEM_READ;
            memresp_msg.opaque = {4'b0, pend[pick].idx};
            memresp_msg.data   = mk_data(pend[pick].addr);
        end
        memreq_rdy = rnd_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
        #1;
        if (reset) begin
            pend.delete();
            phase = 0; stalled = 0; drain_n = 0;
        end else begin
            outs   = issued - responded;
            exp_rv = phase == 1 && issued < 16 && outs < MAXO;
            exp_sr = phase == 1 && outs > 0;
            checks++; if (refill_req_rdy !== (phase == 0)) $display("FAIL req_rdy cyc=%0d got=%b exp=%b", cyc, refill_req_rdy, phase == 0); else passes++;
            checks++; if (memreq_val !== exp_rv) $display("FAIL memreq_val cyc=%0d got=%b exp=%b", cyc, memreq_val, exp_rv); else passes++;
            checks++; if (memresp_rdy !== exp_sr) $display("FAIL memresp_rdy cyc=%0d got=%b exp=%b", cyc, memresp_rdy, exp_sr); else passes++;
            checks++; if (word_val !== (memresp_val && exp_sr)) $display("FAIL word_val cyc=%0d got=%b exp=%b", cyc, word_val, memresp_val && exp_sr); else passes++;
            checks++; if (refill_done !== (phase == 2)) $display("FAIL refill_done cyc=%0d got=%b exp=%b", cyc, refill_done, phase == 2); else passes++;
            if (stalled) begin
                checks++;
                if (memreq_val !== 1'b1 || memreq_msg !== held)
                    $display("FAIL req_hold cyc=%0d got=%b/%h exp=1/%h", cyc, memreq_val, memreq_msg, held);
                else passes++;
            end
            if (memreq_val && memreq_rdy) begin
                exp_req = '{MEM_READ, {4'b0, 4'(issued)}, {base, 4'(issued), 2'b00}, 2'd0, 32'd0};
                checks++; if (memreq_msg !== exp_req) $display("FAIL req_msg cyc=%0d got=%h exp=%h", cyc, memreq_msg, exp_req); else passes++;
                pend.push_back('{memreq_msg.opaque[3:0], memreq_msg.addr, cyc + lat});
                if (issued == 0) first_iss = cyc - acc_cyc;
                last_iss = cyc - acc_cyc;
                issued++;
                if (pend.size() > max_pend) max_pend = pend.size();
            end
            if (word_val && pick >= 0) begin
                checks++; if (word_idx !== pend[pick].idx) $display("FAIL word_idx cyc=%0d got=%0d exp=%0d", cyc, word_idx, pend[pick].idx); else passes++;
                checks++; if (word_data !== mk_data({base, pend[pick].idx, 2'b00})) $display("FAIL word_data cyc=%0d got=%h exp=%h", cyc, word_data, mk_data({base, pend[pick].idx, 2'b00})); else passes++;
                seen[pend[pick].idx]++;
                word_order.push_back(int'(pend[pick].idx));
                pend.delete(pick);
                responded++;
                if (mode == 1) drain_n--;
            end
            stalled = memreq_val && !memreq_rdy;
            held = memreq_msg;
            if (phase == 1 && !exp_rv && issued < 16) stall_cycles++;
            if (refill_done) begin
                done_cnt++; done_abs = cyc; done_rel = cyc - acc_cyc;
            end
            if (phase == 0) begin
                if (refill_req_val) begin
                    phase = 1; base = refill_req_addr[31:6]; issued = 0; responded = 0;
                    foreach (seen[i]) seen[i] = 0;
                    word_order.delete();
                    acc_cyc = cyc; acc_cnt++; stall_cycles = 0; max_pend = 0; drain_n = 0;
                end
            end else if (phase == 1) begin
                if (issued == 16 && responded == 16) phase = 2;
            end else phase = 0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_refill(input logic [31:0] addr, input bit hold);
        int n, a0, d0;
        refill_req_addr = addr; refill_req_val = 1; a0 = acc_cnt; n = 0;
        while (acc_cnt == a0 && n < 50) begin tick(); n++; end
        if (!hold) refill_req_val = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < 4000) begin tick(); n++; end
        checks++; if (done_cnt != d0 + 1) $display("FAIL refill_timeout addr=%h got=%0d exp=1", addr, done_cnt - d0); else passes++;
        checks++; if (issued != 16 || responded != 16) $display("FAIL refill_counts addr=%h got=%0d/%0d exp=16/16", addr, issued, responded); else passes++;
        for (int i = 0; i < 16; i++) begin
            checks++; if (seen[i] != 1) $display("FAIL word_seen idx=%0d got=%0d exp=1", i, seen[i]); else passes++;
        end
    endtask

    task automatic test_reset();
        reset = 1; tick(); tick();
        reset = 0; #1;
        checks++;
        if ({refill_req_rdy, memreq_val, memresp_rdy, word_val, refill_done} !== 5'b10000)
            $display("FAIL reset_outs got=%b exp=10000", {refill_req_rdy, memreq_val, memresp_rdy, word_val, refill_done});
        else passes++;
        repeat (3) tick();
    endtask

    task automatic test_basic();
        bit ok;
        lat = 1; mode = 0; rnd_rdy = 0;
        run_refill(32'h0000_1234, 0);
        checks++; if (first_iss != 1) $display("FAIL first_issue got=%0d exp=1", first_iss); else passes++;
        checks++; if (last_iss != 16) $display("FAIL last_issue got=%0d exp=16", last_iss); else passes++;
        checks++; if (done_rel != 18) $display("FAIL done_cycle got=%0d exp=18", done_rel); else passes++;
        ok = word_order.size() == 16;
        foreach (word_order[i]) if (word_order[i] != i) ok = 0;
        checks++; if (!ok) $display("FAIL in_order got=%p exp=0..15", word_order); else passes++;
        tick();
    endtask

    task automatic test_stall();
        lat = 10; mode = 0;
        run_refill($urandom, 0);
        checks++; if (max_pend != MAXO) $display("FAIL max_outstanding got=%0d exp=%0d", max_pend, MAXO); else passes++;
        checks++; if (stall_cycles == 0) $display("FAIL stall_seen got=0 exp=>0"); else passes++;
        tick();
    endtask

    task automatic test_reorder();
        lat = 2; mode = 1;
        run_refill($urandom, 0);
        checks++;
        if (word_order.size() < 4 || word_order[0] != 3 || word_order[1] != 2 || word_order[2] != 1 || word_order[3] != 0)
            $display("FAIL reverse_batch got=%p exp=3,2,1,0,...", word_order);
        else passes++;
        tick();
        mode = 0;
    endtask

    task automatic test_backpressure();
        lat = 3; mode = 2; rnd_rdy = 1;
        repeat (3) run_refill($urandom, 0);
        tick();
        mode = 0; rnd_rdy = 0;
    endtask

    task automatic test_reset_mid();
        int n, a0;
        lat = 1; mode = 0;
        refill_req_addr = $urandom; refill_req_val = 1; a0 = acc_cnt; n = 0;
        while (acc_cnt == a0 && n < 50) begin tick(); n++; end
        refill_req_val = 0;
        while (responded < 7 && n < 200) begin tick(); n++; end
        checks++; if (responded != 7) $display("FAIL partial_resp got=%0d exp=7", responded); else passes++;
        reset = 1; tick();
        reset = 0; #1;
        checks++;
        if ({refill_req_rdy, memreq_val, word_val} !== 3'b100)
            $display("FAIL reset_mid got=%b exp=100", {refill_req_rdy, memreq_val, word_val});
        else passes++;
        tick();
        run_refill(32'hABCD_0040, 0);
        tick();
    endtask

    task automatic test_back_to_back();
        int da;
        lat = 1; mode = 0;
        run_refill($urandom, 1);
        da = done_abs;
        run_refill($urandom, 1);
        checks++; if (acc_cyc != da + 1) $display("FAIL b2b_accept got=%0d exp=%0d", acc_cyc, da + 1); else passes++;
        checks++; if (done_rel != 18) $display("FAIL b2b_done got=%0d exp=18", done_rel); else passes++;
        refill_req_val = 0;
        repeat (2) tick();
    endtask

    initial begin
        reset = 1; refill_req_val = 0; refill_req_addr = '0; memreq_rdy = 0;
        memresp_val = 0; memresp_msg = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_reorder();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
